// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester round-robin arbiter in front of a single BRAM port

module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  we_0,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [15:0]           grant_cnt_0,
    output logic [15:0]           grant_cnt_1
);

    logic prio;
    logic tag_valid;
    logic tag_id;

    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (!reset) begin
            gnt_0 = req_0 && (!req_1 || !prio);
            gnt_1 = req_1 && (!req_0 || prio);
        end
    end

    // Idle cycles leave requester 0's address/data on the port; only en/we matter.
    always_comb begin
        bram_en   = gnt_0 | gnt_1;
        bram_we   = (gnt_0 & we_0) | (gnt_1 & we_1);
        bram_addr = gnt_1 ? addr_1 : addr_0;
        bram_din  = gnt_1 ? wdata_1 : wdata_0;
    end

    // The tag is masked during reset so a read in flight when reset hits never returns.
    always_comb begin
        rvalid_0 = tag_valid & ~tag_id & ~reset;
        rvalid_1 = tag_valid &  tag_id & ~reset;
        rdata    = (rvalid_0 | rvalid_1) ? bram_dout : '0;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            prio        <= 1'b0;
            tag_valid   <= 1'b0;
            tag_id      <= 1'b0;
            grant_cnt_0 <= '0;
            grant_cnt_1 <= '0;
        end else begin
            if (gnt_0) begin
                prio <= 1'b1;
            end else if (gnt_1) begin
                prio <= 1'b0;
            end
            tag_valid <= bram_en & ~bram_we;
            tag_id    <= gnt_1;
            if (gnt_0 && grant_cnt_0 != 16'hFFFF) begin
                grant_cnt_0 <= grant_cnt_0 + 16'd1;
            end
            if (gnt_1 && grant_cnt_1 != 16'hFFFF) begin
                grant_cnt_1 <= grant_cnt_1 + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter

module tb_bram_port_arbiter;

    logic        clk_in;
    logic        reset;
    logic        req_0, req_1, we_0, we_1;
    logic [11:0] addr_0, addr_1;
    logic [7:0]  wdata_0, wdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [7:0]  rdata;
    logic        bram_en, bram_we;
    logic [11:0] bram_addr;
    logic [7:0]  bram_din, bram_dout;
    logic [15:0] grant_cnt_0, grant_cnt_1;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] mem [0:4095];

    bram_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk_in(clk_in), .reset(reset),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata(rdata), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Read-first BRAM with one-cycle registered output
    always @(posedge clk_in) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            bram_dout <= mem[bram_addr];
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs;
        req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
    endtask

    initial begin
        reset = 1; idle_inputs();
        addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
        tick();
        req_0 = 1; req_1 = 1; #1;
        chk("rst_gnt_0", gnt_0, 0);
        chk("rst_gnt_1", gnt_1, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_we", bram_we, 0);
        tick();
        chk("rst_cnt_0", grant_cnt_0, 0);
        chk("rst_cnt_1", grant_cnt_1, 0);
        chk("rst_rdata", rdata, 0);

        // Preload BRAM[5]=A3 and BRAM[6]=11 through the arbiter, then reset again
        reset = 0; idle_inputs();
        req_0 = 1; we_0 = 1; addr_0 = 12'h005; wdata_0 = 8'hA3; #1;
        chk("pre_w0_gnt", gnt_0, 1);
        chk("pre_w0_we", bram_we, 1);
        tick();
        idle_inputs();
        req_1 = 1; we_1 = 1; addr_1 = 12'h006; wdata_1 = 8'h11; #1;
        chk("pre_w1_gnt", gnt_1, 1);
        chk("pre_w0_no_rvalid", rvalid_0, 0);
        tick();
        idle_inputs(); reset = 1;
        tick();
        reset = 0;

        // Single read
        req_0 = 1; we_0 = 0; addr_0 = 12'h005; #1;
        chk("rd_gnt_0", gnt_0, 1);
        chk("rd_gnt_1", gnt_1, 0);
        chk("rd_bram_en", bram_en, 1);
        chk("rd_bram_we", bram_we, 0);
        chk("rd_bram_addr", bram_addr, 12'h005);
        chk("rd_rvalid_0_T", rvalid_0, 0);
        tick();
        idle_inputs(); #1;
        chk("rd_rvalid_0_T1", rvalid_0, 1);
        chk("rd_rvalid_1_T1", rvalid_1, 0);
        chk("rd_rdata_T1", rdata, 8'hA3);
        tick(); #1;
        chk("rd_rvalid_0_T2", rvalid_0, 0);
        chk("rd_rdata_T2", rdata, 0);
        chk("rd_cnt_0", grant_cnt_0, 1);

        // Contention after reset: strict alternation starting with port 0
        reset = 1;
        tick();
        reset = 0;
        req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0; addr_0 = 12'h005; addr_1 = 12'h006;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("ct_gnt_0_%0d", i), gnt_0, (i % 2) == 0);
            chk($sformatf("ct_gnt_1_%0d", i), gnt_1, (i % 2) == 1);
            chk($sformatf("ct_rvalid_0_%0d", i), rvalid_0, (i % 2) == 1);
            chk($sformatf("ct_rvalid_1_%0d", i), rvalid_1, i > 0 && (i % 2) == 0);
            if (i > 0) chk($sformatf("ct_rdata_%0d", i), rdata, (i % 2) ? 8'hA3 : 8'h11);
            tick();
        end
        idle_inputs(); #1;
        chk("ct_last_rvalid_1", rvalid_1, 1);
        chk("ct_last_rdata", rdata, 8'h11);
        chk("ct_cnt_0", grant_cnt_0, 3);
        chk("ct_cnt_1", grant_cnt_1, 3);
        tick();

        // Port 1 writes 5C to 0FF, port 0 reads it back
        req_1 = 1; we_1 = 1; addr_1 = 12'h0FF; wdata_1 = 8'h5C; #1;
        chk("wr_gnt_1", gnt_1, 1);
        chk("wr_bram_we", bram_we, 1);
        chk("wr_bram_addr", bram_addr, 12'h0FF);
        chk("wr_bram_din", bram_din, 8'h5C);
        tick();
        idle_inputs();
        req_0 = 1; addr_0 = 12'h0FF; #1;
        chk("wr_rd_gnt_0", gnt_0, 1);
        chk("wr_no_rvalid_1", rvalid_1, 0);
        chk("wr_no_rvalid_0", rvalid_0, 0);
        tick();
        idle_inputs(); #1;
        chk("wr_rd_rvalid_0", rvalid_0, 1);
        chk("wr_rd_rdata", rdata, 8'h5C);
        tick();

        // Read granted in T, reset in T+1: no return, state cleared
        req_0 = 1; addr_0 = 12'h005; #1;
        chk("rr_gnt_0", gnt_0, 1);
        tick();
        reset = 1; req_0 = 1; req_1 = 1; #1;
        chk("rr_rvalid_0_T1", rvalid_0, 0);
        chk("rr_rvalid_1_T1", rvalid_1, 0);
        chk("rr_rdata_T1", rdata, 0);
        chk("rr_gnt_0_T1", gnt_0, 0);
        chk("rr_gnt_1_T1", gnt_1, 0);
        chk("rr_bram_en_T1", bram_en, 0);
        tick();
        reset = 0; idle_inputs(); #1;
        chk("rr_rvalid_0_T2", rvalid_0, 0);
        chk("rr_rvalid_1_T2", rvalid_1, 0);
        chk("rr_cnt_0", grant_cnt_0, 0);
        chk("rr_cnt_1", grant_cnt_1, 0);
        req_0 = 1; req_1 = 1; #1;
        chk("rr_prio0_gnt_0", gnt_0, 1);
        chk("rr_prio0_gnt_1", gnt_1, 0);
        tick();

        // Idle 10 cycles: prio (now 1) and counters hold
        idle_inputs(); addr_0 = 12'h123; addr_1 = 12'h456;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("id_bram_en_%0d", i), bram_en, 0);
            chk($sformatf("id_gnt_%0d", i), {gnt_0, gnt_1}, 0);
            tick();
        end
        #1;
        chk("id_bram_addr", bram_addr, 12'h123);
        chk("id_cnt_0", grant_cnt_0, 1);
        chk("id_cnt_1", grant_cnt_1, 0);
        req_0 = 1; req_1 = 1; #1;
        chk("id_prio_gnt_1", gnt_1, 1);
        chk("id_prio_gnt_0", gnt_0, 0);
        tick();

        // Saturation: grant_cnt_0 starts at 1, 65540 more grants
        idle_inputs(); req_0 = 1;
        for (int i = 0; i < 65540; i++) tick();
        idle_inputs(); #1;
        chk("sat_cnt_0", grant_cnt_0, 16'hFFFF);
        chk("sat_cnt_1", grant_cnt_1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 8: BRAM data width.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_0, req_1  input  1 each  access request from requester 0 / 1; held high until granted.
REQ-006 we_0, we_1  input  1 each  1 = write, 0 = read; qualified by req_N.
REQ-007 addr_0, addr_1  input  ADDR_WIDTH each  access address.
REQ-008 wdata_0, wdata_1  input  DATA_WIDTH each  write data.
REQ-009 gnt_0, gnt_1  output  1 each  access accepted this cycle; combinational.
REQ-010 rvalid_0, rvalid_1  output  1 each  read data valid for that requester.
REQ-011 rdata  output  DATA_WIDTH  read data, shared by both requesters, qualified by rvalid_N.
REQ-012 bram_en, bram_we  output  1 each  drive the BRAM port enable and write enable.
REQ-013 bram_addr  output  ADDR_WIDTH  BRAM port address.
REQ-014 bram_din  output  DATA_WIDTH  BRAM port write data.
REQ-015 bram_dout  input  DATA_WIDTH  BRAM port read data, registered, 1-cycle latency.
REQ-016 grant_cnt_0, grant_cnt_1  output  16 each  saturating count of grants per requester.

Function
REQ-017 The block grants at most one requester per cycle: gnt_0 & gnt_1 is never 1.
REQ-018 A single requesting port is granted in the same cycle.
REQ-019 When both request, the port named by the 1-bit priority pointer prio wins.
REQ-020 After a grant to port N, prio moves to the other port at the next edge; with no grant, prio holds.
REQ-021 Consequence: under continuous contention, grants alternate 0,1,0,1 and neither port waits more than 1 cycle.
REQ-022 In a grant cycle, the BRAM port carries the winner's signals: bram_en=1, bram_we=we_N, bram_addr=addr_N, bram_din=wdata_N.
REQ-023 With no grant: bram_en=0 and bram_we=0; bram_addr and bram_din carry requester 0's values (don't-care).
REQ-024 A read grant to port N in cycle T pulses rvalid_N high for exactly cycle T+1, with rdata=bram_dout.
REQ-025 A write grant produces no rvalid.
REQ-026 The read-return tag is a registered valid bit plus a port id, so back-to-back reads by either port return in grant order, one per cycle.
REQ-027 rdata equals bram_dout whenever rvalid_0 | rvalid_1; otherwise rdata is 0.
REQ-028 grant_cnt_N increments by 1 on each gnt_N cycle and saturates at 16'hFFFF with no wrap.
REQ-029 A requester may drop req_N only after the gnt_N cycle; dropping it earlier withdraws the request with no side effect.

Reset
REQ-030 While reset=1: gnt_0=gnt_1=0, bram_en=0 and bram_we=0, regardless of req inputs.
REQ-031 At the edge where reset=1: prio=0, rvalid tag cleared, grant_cnt_0=grant_cnt_1=0, rdata=0.
REQ-032 A read granted in the cycle immediately before reset asserts returns no rvalid; the tag is flushed.
REQ-033 In the first cycle after reset deasserts, arbitration is normal and requester 0 has priority.

Verification
REQ-034 Single read: reset, then req_0=1, we_0=0, addr_0=12'h005 with BRAM[5]=8'hA3 -> gnt_0 in cycle T; rvalid_0=1 and rdata=8'hA3 in T+1; rvalid_1=0 throughout.
REQ-035 Contention: req_0=req_1=1, both reads, held 6 cycles after reset -> gnt sequence 0,1,0,1,0,1; rvalid sequence 0,1,0,1,0,1 lagging by one cycle; grant_cnt_0=grant_cnt_1=3.
REQ-036 Write then read: port 1 writes 8'h5C to 12'h0FF, then port 0 reads 12'h0FF -> rvalid_0 with rdata=8'h5C; no rvalid for the write.
REQ-037 Reset mid-read: read granted in cycle T, reset=1 in T+1 -> rvalid_0=rvalid_1=0 in T+1 and T+2; grant counters=0; prio=0.
REQ-038 Saturation: force 65536 grants to port 0 -> grant_cnt_0 holds 16'hFFFF; grant_cnt_1 unchanged.
REQ-039 Idle: req_0=req_1=0 for 10 cycles -> bram_en=0, no gnt, prio unchanged, counters unchanged.
